// File: rtl/round_robin_arbiter_pkg.sv
// round_robin_arbiter_pkg: state encodings and pointer-width helper shared by the arbiter files
package round_robin_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic int ptr_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/round_robin_arbiter_priority_pick.sv
// rr_priority_pick: combinational rotating priority search, lowest request at or above ptr, else lowest overall
module rr_priority_pick
  import round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PW    = ptr_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [WIDTH-1:0] o_pick,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);
  logic [2*WIDTH-1:0] w_dbl, w_msk, w_lsb;
  assign w_dbl  = {i_req, i_req};
  assign w_msk  = w_dbl & ({(2*WIDTH){1'b1}} << i_ptr);
  assign w_lsb  = w_msk & (~w_msk + (2*WIDTH)'(1));
  assign o_pick = w_lsb[WIDTH-1:0] | w_lsb[2*WIDTH-1:WIDTH];
  assign o_any  = |i_req;
  // binary index of the one-hot pick, used later to advance the pointer
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < WIDTH; i++) o_idx = o_idx | (o_pick[i] ? PW'(i) : '0);
  end
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: fair N-way arbiter with registered one-hot grant and valid/ready hold; ROUND_ROBIN_ARBITER_LOCK_EN adds iLock burst ownership
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iReq,
  input  logic             iReady,
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  input  logic             iLock,
`endif
  output logic             oValid,
  output logic [WIDTH-1:0] oGrant
);
  localparam int PW = ptr_w(WIDTH);
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_grant, w_pick;
  logic [PW-1:0]    r_idx, r_ptr, w_idx, w_ptr_inc, w_ptr_arb;
  logic             w_any, w_acc, w_arb, w_hold;
  assign w_acc     = (r_state == ST_GRANT) && iReady;
  assign w_arb     = (r_state == ST_IDLE) || w_acc;
  assign w_ptr_inc = (r_idx == LAST) ? '0 : r_idx + PW'(1);
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  assign w_hold    = w_acc && iLock && iReq[r_idx];
`else
  assign w_hold    = 1'b0;
`endif
  // the pick must already see the pointer moved past the grant being accepted, so rotation has no bubble
  assign w_ptr_arb = w_acc ? w_ptr_inc : r_ptr;
  rr_priority_pick #(.WIDTH(WIDTH), .PW(PW)) u_pick (
    .i_req  (iReq),
    .i_ptr  (w_ptr_arb),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );
  // state, grant and pointer change only at arbitration points; a locked accept keeps everything as is
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (w_arb && !w_hold) begin
      r_state <= w_any ? ST_GRANT : ST_IDLE;
      r_grant <= w_pick;
      r_idx   <= w_idx;
      r_ptr   <= w_ptr_arb;
    end
  end
  assign oValid = (r_state == ST_GRANT);
  assign oGrant = r_grant;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed and random scoreboard bench for round_robin_arbiter at WIDTH=4
module tb_round_robin_arbiter;
  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [3:0] iReq = '0;
  logic       iReady = 1'b0;
  logic       lock = 1'b0;
  logic       oValid;
  logic [3:0] oGrant;
  int n_chk = 0;
  int n_fail = 0;
  bit m_valid = 0;
  int m_g = 0;
  int m_ptr = 0;
  logic [4:0] q_mdl[$];
  logic [4:0] q_dir[$];
  bit         q_has[$];
  string      q_tag[$];
  always #5 iClk = ~iClk;
  round_robin_arbiter #(.WIDTH(4)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iReq   (iReq),
    .iReady (iReady),
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    .iLock  (lock),
`endif
    .oValid (oValid),
    .oGrant (oGrant)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input bit rst, input logic [3:0] req, input bit rdy, input bit lk);
    bit acc, lk_eff, found;
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 1'b0;
`endif
    if (rst) begin
      m_valid = 0;
      m_ptr = 0;
      m_g = 0;
    end else begin
      acc = m_valid && rdy;
      if (!(acc && lk_eff && req[m_g]) && (!m_valid || rdy)) begin
        if (acc) m_ptr = (m_g + 1) % 4;
        found = 0;
        for (int k = 0; k < 4; k++)
          if (!found && req[(m_ptr + k) % 4]) begin
            found = 1;
            m_g = (m_ptr + k) % 4;
          end
        m_valid = found;
      end
    end
  endtask
  task automatic step(input bit rst, input logic [3:0] req, input bit rdy, input bit lk,
                      input logic [4:0] dir, input bit has_dir, input string tag);
    logic [4:0] mdl, d;
    bit h;
    string t;
    @(negedge iClk);
    iRst = rst;
    iReq = req;
    iReady = rdy;
    lock = lk;
    model(rst, req, rdy, lk);
    q_mdl.push_back({m_valid, m_valid ? 4'(1 << m_g) : 4'b0000});
    q_dir.push_back(dir);
    q_has.push_back(has_dir);
    q_tag.push_back(tag);
    @(posedge iClk);
    #1;
    mdl = q_mdl.pop_front();
    d = q_dir.pop_front();
    h = q_has.pop_front();
    t = q_tag.pop_front();
    chk({t, "_model"}, {27'd0, oValid, oGrant}, {27'd0, mdl});
    if (h) chk({t, "_spec"}, {27'd0, oValid, oGrant}, {27'd0, d});
    chk("onehot0", 32'($onehot0(oGrant)), 32'd1);
    chk("zero_iff_invalid", 32'(|oGrant), 32'(oValid));
  endtask
  initial begin
    step(1, 4'b1111, 1, 0, 5'b0_0000, 1, "reset0");
    step(1, 4'b1111, 1, 0, 5'b0_0000, 1, "reset1");
    step(0, 4'b1111, 0, 0, 5'b1_0001, 1, "first_grant");
    step(0, 4'b1111, 1, 0, 5'b1_0010, 1, "rot1");
    step(0, 4'b1111, 1, 0, 5'b1_0100, 1, "rot2");
    step(0, 4'b1111, 1, 0, 5'b1_1000, 1, "rot3");
    step(0, 4'b1111, 1, 0, 5'b1_0001, 1, "rot_wrap");
    step(0, 4'b1111, 1, 0, 5'b1_0010, 1, "stall_grant");
    step(0, 4'b1111, 0, 0, 5'b1_0010, 1, "stall0");
    for (int i = 0; i < 4; i++) step(0, 4'b1101, 0, 0, 5'b1_0010, 1, "stall_drop");
    step(0, 4'b1101, 1, 0, 5'b1_0100, 1, "stall_release");
    step(0, 4'b0101, 1, 0, 5'b1_0001, 1, "wrap_skip");
    step(0, 4'b0101, 1, 0, 5'b1_0100, 1, "skip_ptr1");
    step(0, 4'b0000, 1, 0, 5'b0_0000, 1, "empty");
    step(0, 4'b0000, 0, 0, 5'b0_0000, 1, "idle");
    step(0, 4'b1000, 0, 0, 5'b1_1000, 1, "idle_req");
    step(0, 4'b0000, 1, 0, 5'b0_0000, 1, "idle_again");
    for (int i = 0; i < 3; i++) step(0, 4'b0100, 1, 0, 5'b1_0100, 1, "single_req");
    step(0, 4'b0000, 1, 0, 5'b0_0000, 1, "single_done");
    step(0, 4'b1111, 1, 1, 5'b1_0100, 0, "mid_reset_setup");
    step(1, 4'b1111, 1, 0, 5'b0_0000, 1, "mid_reset");
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
    step(0, 4'b1111, 0, 0, 5'b1_0001, 1, "lock_first");
    step(0, 4'b1111, 1, 1, 5'b1_0001, 1, "lock1");
    step(0, 4'b1111, 1, 1, 5'b1_0001, 1, "lock2");
    step(0, 4'b1111, 1, 0, 5'b1_0010, 1, "lock_release");
    step(0, 4'b1101, 1, 1, 5'b1_0100, 1, "lock_noreq");
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
           1'($urandom), 1'($urandom), 5'b0_0000, 0, "random");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
